// File: rtl/sram_ahb_bank_ctl.sv
// sram_ahb_bank_ctl
//   AHB-lite slave in front of NUM_BANK single-port 32-bit SRAM banks that
//   together form one DWIDTH-wide word per row. Reads and writes complete
//   with no wait states. A one-entry posted-write buffer, forwarded into
//   read data, hides the write->read port conflict. Illegal accesses receive
//   a two-cycle ERROR response and never touch the SRAM.
//
// Ports
//   hclk, hresetn        clock, asynchronous active-low reset
//   hsel, htrans, haddr,
//   hsize, hwrite        AHB address phase (hsize 0/1/2 = byte/half/word,
//                        4 = full width)
//   hwdata               AHB write data (data phase)
//   hrdata, hready, hresp AHB response (hrdata is 0 outside read data phases)
//   mem_addr             shared row address for all banks
//   mem_cs               per-bank chip select
//   mem_we, mem_ben      write strobe and byte enables (bank b uses [4b+3:4b])
//   mem_wdata, mem_rdata SRAM data (read data arrives one cycle after mem_cs)
//   dbg_state            error-response FSM state, for observation
//
// Handshake: an address phase is taken when hsel & htrans[1] & hready.
// Its data phase is the following cycle; hready is only low in the first
// cycle of an ERROR response, during which address phases are ignored.
module sram_ahb_bank_ctl #(
  parameter int unsigned NUM_BANK  = 4,
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  localparam int unsigned DWIDTH   = 32 * NUM_BANK,
  localparam int unsigned NBEN     = DWIDTH / 8,
  localparam int unsigned RAW      = $clog2(DEPTH),
  localparam int unsigned BW       = $clog2(NUM_BANK),
  localparam int unsigned BOFF     = BW + 2,
  localparam int unsigned AW       = RAW + BOFF
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic                hsel,
  input  logic [1:0]          htrans,
  input  logic [31:0]         haddr,
  input  logic [3:0]          hsize,
  input  logic                hwrite,
  input  logic [DWIDTH-1:0]   hwdata,
  output logic [DWIDTH-1:0]   hrdata,
  output logic                hready,
  output logic                hresp,
  output logic [RAW-1:0]      mem_addr,
  output logic [NUM_BANK-1:0] mem_cs,
  output logic                mem_we,
  output logic [NBEN-1:0]     mem_ben,
  output logic [DWIDTH-1:0]   mem_wdata,
  input  logic [DWIDTH-1:0]   mem_rdata,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ERR1 = 2'd1, ST_ERR2 = 2'd2} err_state_e;

  err_state_e state_q, state_d;

  // Address-phase decode
  logic                accept, region_ok, size_ok, misalign, addr_err;
  logic                ap_full, ap_rd, ap_wr;
  logic [BW-1:0]       ap_bank;
  logic [RAW-1:0]      ap_row;
  logic [3:0]          ap_lane;
  logic [NBEN-1:0]     ap_mask;
  logic [NUM_BANK-1:0] ap_cs;
  logic                unused_htrans0;

  assign unused_htrans0 = htrans[0];
  assign accept    = hsel & htrans[1] & hready;
  assign ap_bank   = haddr[BOFF-1:2];
  assign ap_row    = haddr[AW-1:BOFF];
  assign region_ok = (haddr[31:AW] == BASE_ADDR[31:AW]);
  assign ap_full   = (hsize == 4'd4);

  always_comb begin
    size_ok  = 1'b1;
    misalign = 1'b0;
    ap_lane  = 4'hF;
    case (hsize)
      4'd0:    ap_lane = 4'b0001 << haddr[1:0];
      4'd1: begin
        misalign = haddr[0];
        ap_lane  = 4'b0011 << haddr[1:0];
      end
      4'd2:    misalign = |haddr[1:0];
      4'd4:    misalign = |haddr[BOFF-1:0];
      default: size_ok = 1'b0;
    endcase
  end

  assign addr_err = ~region_ok | ~size_ok | misalign;
  assign ap_rd    = accept & ~addr_err & ~hwrite;
  assign ap_wr    = accept & ~addr_err & hwrite;
  assign ap_mask  = ap_full ? '1 : (NBEN'(ap_lane) << {ap_bank, 2'b00});
  assign ap_cs    = ap_full ? '1 : (NUM_BANK'(1) << ap_bank);

  // Error-response FSM
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && addr_err) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = (accept && addr_err) ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hready    = (state_q != ST_ERR1);
    hresp     = (state_q != ST_IDLE);
    dbg_state = state_q;
  end

  // Data-phase context, shared by reads and writes (only one is live)
  logic               rd_dp_q, wr_dp_q, dp_full_q;
  logic [BW-1:0]      dp_bank_q;
  logic [RAW-1:0]     dp_row_q;
  logic [NBEN-1:0]    dp_mask_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rd_dp_q   <= 1'b0;
      wr_dp_q   <= 1'b0;
      dp_full_q <= 1'b0;
      dp_bank_q <= '0;
      dp_row_q  <= '0;
      dp_mask_q <= '0;
    end else begin
      rd_dp_q <= ap_rd;
      wr_dp_q <= ap_wr;
      if (accept) begin
        dp_full_q <= ap_full;
        dp_bank_q <= ap_bank;
        dp_row_q  <= ap_row;
        dp_mask_q <= ap_mask;
      end
    end
  end

  // Narrow write data is replicated so every bank lane sees the same word.
  logic [DWIDTH-1:0] ent_data;
  assign ent_data = dp_full_q ? hwdata : {NUM_BANK{hwdata[31:0]}};

  function automatic logic [NUM_BANK-1:0] mask_to_cs(input logic [NBEN-1:0] m);
    logic [NUM_BANK-1:0] cs;
    for (int b = 0; b < NUM_BANK; b++) cs[b] = |m[4*b +: 4];
    return cs;
  endfunction

  // Posted-write buffer and SRAM port arbitration (reads win the port)
  logic              buf_vld_q, buf_vld_d;
  logic [RAW-1:0]    buf_row_q, buf_row_d;
  logic [NBEN-1:0]   buf_mask_q, buf_mask_d;
  logic [DWIDTH-1:0] buf_data_q, buf_data_d;

  always_comb begin
    buf_vld_d  = buf_vld_q;
    buf_row_d  = buf_row_q;
    buf_mask_d = buf_mask_q;
    buf_data_d = buf_data_q;
    mem_cs     = '0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_ben    = '0;
    mem_wdata  = '0;
    if (ap_rd) begin
      mem_cs   = ap_cs;
      mem_addr = ap_row;
    end else if (buf_vld_q) begin
      mem_cs    = mask_to_cs(buf_mask_q);
      mem_we    = 1'b1;
      mem_addr  = buf_row_q;
      mem_ben   = buf_mask_q;
      mem_wdata = buf_data_q;
      buf_vld_d = 1'b0;
    end else if (wr_dp_q) begin
      mem_cs    = mask_to_cs(dp_mask_q);
      mem_we    = 1'b1;
      mem_addr  = dp_row_q;
      mem_ben   = dp_mask_q;
      mem_wdata = ent_data;
    end
    // A new write entry is parked whenever it could not go straight out.
    if (wr_dp_q && (ap_rd || buf_vld_q)) begin
      buf_vld_d  = 1'b1;
      buf_row_d  = dp_row_q;
      buf_mask_d = dp_mask_q;
      buf_data_d = ent_data;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      buf_vld_q  <= 1'b0;
      buf_row_q  <= '0;
      buf_mask_q <= '0;
      buf_data_q <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      buf_row_q  <= buf_row_d;
      buf_mask_q <= buf_mask_d;
      buf_data_q <= buf_data_d;
    end
  end

  // Read data: buffered bytes for the same row override SRAM bytes.
  logic [DWIDTH-1:0] fwd_data;
  always_comb begin
    fwd_data = mem_rdata;
    if (buf_vld_q && (buf_row_q == dp_row_q)) begin
      for (int i = 0; i < NBEN; i++)
        if (buf_mask_q[i]) fwd_data[8*i +: 8] = buf_data_q[8*i +: 8];
    end
    hrdata = '0;
    if (rd_dp_q) begin
      if (dp_full_q) hrdata = fwd_data;
      else           hrdata[31:0] = fwd_data[32*dp_bank_q +: 32];
    end
  end

endmodule
